// File: rtl/axi_read_master.sv
// ============================================================================
// axi_read_master : single-outstanding AXI4 read initiator (AR + R channels)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module axi_read_master #(
  parameter int              ID_W      = 4,
  parameter int              ADDR_W    = 32,
  parameter int              DATA_W    = 32,
  parameter int              LEN_W     = 4,
  parameter logic [ID_W-1:0] MASTER_ID = '0
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  // core request port
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [2:0]        req_size,
  input  logic [1:0]        req_burst,
  // core response port
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_last,
  output logic              done,
  output logic [1:0]        done_resp,
  output logic              done_proto_err,
  output logic              busy,
  // AXI read address channel
  output logic [ID_W-1:0]   ARID,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [LEN_W-1:0]  ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic              ARVALID,
  input  logic              ARREADY,
  // AXI read data channel
  input  logic [ID_W-1:0]   RID,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [2:0]          size_q, size_d;
  logic [1:0]          burst_q, burst_d;
  logic [LEN_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [1:0]          err_resp_q, err_resp_d;
  logic                proto_err_q, proto_err_d;
  logic [1:0]          done_resp_q, done_resp_d;
  logic                done_proto_err_q, done_proto_err_d;

  logic                in_data;
  logic                r_hs;

  assign in_data = (state_q == S_DATA);
  assign r_hs    = in_data && RVALID && resp_ready;

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    len_d            = len_q;
    size_d           = size_q;
    burst_d          = burst_q;
    beat_cnt_d       = beat_cnt_q;
    err_resp_d       = err_resp_q;
    proto_err_d      = proto_err_q;
    done_resp_d      = done_resp_q;
    done_proto_err_d = done_proto_err_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d      = req_addr;
          len_d       = req_len;
          size_d      = req_size;
          burst_d     = req_burst;
          beat_cnt_d  = '0;
          err_resp_d  = 2'b00;
          proto_err_d = 1'b0;
          state_d     = S_ADDR;
        end
      end
      S_ADDR: begin
        if (ARREADY) state_d = S_DATA;
      end
      S_DATA: begin
        if (r_hs) begin
          if (beat_cnt_q != {LEN_W{1'b1}}) beat_cnt_d = beat_cnt_q + 1'b1;
          // RRESP[1] clear means OKAY/EXOKAY, which never raises the severity
          if (RRESP[1] && (RRESP > err_resp_q)) err_resp_d = RRESP;
          if (RID != MASTER_ID) proto_err_d = 1'b1;
          if (RLAST) begin
            if (beat_cnt_q != len_q) proto_err_d = 1'b1;
            done_resp_d      = err_resp_d;
            done_proto_err_d = proto_err_d;
            state_d          = S_DONE;
          end else if (beat_cnt_q == len_q) begin
            proto_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q          <= S_IDLE;
      addr_q           <= '0;
      len_q            <= '0;
      size_q           <= '0;
      burst_q          <= '0;
      beat_cnt_q       <= '0;
      err_resp_q       <= '0;
      proto_err_q      <= 1'b0;
      done_resp_q      <= '0;
      done_proto_err_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      len_q            <= len_d;
      size_q           <= size_d;
      burst_q          <= burst_d;
      beat_cnt_q       <= beat_cnt_d;
      err_resp_q       <= err_resp_d;
      proto_err_q      <= proto_err_d;
      done_resp_q      <= done_resp_d;
      done_proto_err_q <= done_proto_err_d;
    end
  end

  assign req_ready      = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);

  assign ARID           = MASTER_ID;
  assign ARADDR         = addr_q;
  assign ARLEN          = len_q;
  assign ARSIZE         = size_q;
  assign ARBURST        = burst_q;
  assign ARVALID        = (state_q == S_ADDR);

  // R channel is a zero-latency pass-through to the core while in DATA
  assign RREADY         = in_data && resp_ready;
  assign resp_valid     = in_data && RVALID;
  assign resp_data      = RDATA;
  assign resp_last      = RLAST;

  assign done           = (state_q == S_DONE);
  assign done_resp      = done_resp_q;
  assign done_proto_err = done_proto_err_q;

endmodule

`default_nettype wire
